writeback_stage_p: RTL and testbench

Parametrised, registered MEM/WB stage plus write-back select for the MIPS pipeline.
- Captures memory/ALU/HI-LO results and control at the MEM/WB boundary.
- Performs sub-word load extraction with byte-offset selection and sign/zero extension.
- Resolves MOVZ/MOVN conditional writes and drives the register-file write port.
- Supports stall and flush; optionally counts retired instructions.

---
 rtl/writeback_stage_p_if.sv | 65 ++++++
 rtl/writeback_stage_p.sv | 171 +++++++++++++++++
 tb/tb_writeback_stage_p.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_stage_p_if.sv
// writeback_stage_p_if: MEM/WB stage bundle between the memory stage and the
// write-back stage.
//   master : upstream side. Drives stage inputs and control (Stall, Flush,
//            InValid, load/move controls). Observes the register-file write
//            port and Valid.
//   slave  : write-back stage side. Mirror image of master.
// Optional macro WB_RETIRE_CNT_EN adds the RetireCount observation signal.
interface writeback_stage_p_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
);
    // stage control
    logic                  Stall;
    logic                  Flush;
    logic                  InValid;

    // captured datapath values
    logic [DATA_W-1:0]     MemoryReadData;
    logic [DATA_W-1:0]     ALUResult;
    logic [DATA_W-1:0]     ReadDataHi;
    logic [DATA_W-1:0]     ReadDataLo;
    logic                  Zero;

    // captured control
    logic [REG_ADDR_W-1:0] InWriteReg;
    logic                  InRegWrite;
    logic                  MemToReg;
    logic                  HiToReg;
    logic                  HiOrLo;
    logic [1:0]            LoadSize;
    logic                  LoadUnsigned;
    logic [1:0]            ByteOffset;
    logic [1:0]            MoveMode;

    // register-file write port
    logic [DATA_W-1:0]     WriteData;
    logic [REG_ADDR_W-1:0] WriteReg;
    logic                  RegWriteEn;
    logic                  Valid;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0]           RetireCount;
`endif

    modport master (
        output Stall, Flush, InValid,
        output MemoryReadData, ALUResult, ReadDataHi, ReadDataLo, Zero,
        output InWriteReg, InRegWrite, MemToReg, HiToReg, HiOrLo,
        output LoadSize, LoadUnsigned, ByteOffset, MoveMode,
        input  WriteData, WriteReg, RegWriteEn, Valid
`ifdef WB_RETIRE_CNT_EN
        , input RetireCount
`endif
    );

    modport slave (
        input  Stall, Flush, InValid,
        input  MemoryReadData, ALUResult, ReadDataHi, ReadDataLo, Zero,
        input  InWriteReg, InRegWrite, MemToReg, HiToReg, HiOrLo,
        input  LoadSize, LoadUnsigned, ByteOffset, MoveMode,
        output WriteData, WriteReg, RegWriteEn, Valid
`ifdef WB_RETIRE_CNT_EN
        , output RetireCount
`endif
    );
endinterface

// File: rtl/writeback_stage_p.sv
// writeback_stage_p: registered MEM/WB pipeline stage with write-back select.
// Captures memory/ALU/HI-LO results and control on Clk, then builds the
// register-file write from the stage registers only. Sub-word loads get
// byte-lane selection and sign/zero extension. MOVZ/MOVN conditions gate the
// write enable.
//   Clk   : clock, all state updates on posedge
//   Rst   : synchronous active-high reset
//   wb    : writeback_stage_p_if.slave. Stage inputs/control in,
//           WriteData/WriteReg/RegWriteEn/Valid out.
// Parameters: DATA_W (32 or 64), REG_ADDR_W.
// Optional macro WB_RETIRE_CNT_EN: adds a 32-bit wrapping retired-instruction
// counter on wb.RetireCount.
module writeback_stage_p #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic               Clk,
    input  logic               Rst,
    writeback_stage_p_if.slave wb
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned WORD_W = 32;

    localparam logic [1:0] LOAD_BYTE = 2'b00;
    localparam logic [1:0] LOAD_HALF = 2'b01;
    localparam logic [1:0] LOAD_WORD = 2'b10;

    localparam logic [1:0] MOVE_ALWAYS = 2'b00;
    localparam logic [1:0] MOVE_Z      = 2'b01;
    localparam logic [1:0] MOVE_N      = 2'b10;

    typedef struct packed {
        logic [DATA_W-1:0]     memData;
        logic [DATA_W-1:0]     aluResult;
        logic [DATA_W-1:0]     hi;
        logic [DATA_W-1:0]     lo;
        logic                  zero;
        logic [REG_ADDR_W-1:0] writeReg;
        logic                  regWrite;
        logic                  memToReg;
        logic                  hiToReg;
        logic                  hiOrLo;
        logic [1:0]            loadSize;
        logic                  loadUnsigned;
        logic [1:0]            byteOffset;
        logic [1:0]            moveMode;
    } stageT;

    stageT stageD;
    stageT stageQ;
    logic  validQ;

    // Gather the incoming instruction into one payload.
    always_comb begin
        stageD              = '0;
        stageD.memData      = wb.MemoryReadData;
        stageD.aluResult    = wb.ALUResult;
        stageD.hi           = wb.ReadDataHi;
        stageD.lo           = wb.ReadDataLo;
        stageD.zero         = wb.Zero;
        stageD.writeReg     = wb.InWriteReg;
        stageD.regWrite     = wb.InRegWrite;
        stageD.memToReg     = wb.MemToReg;
        stageD.hiToReg      = wb.HiToReg;
        stageD.hiOrLo       = wb.HiOrLo;
        stageD.loadSize     = wb.LoadSize;
        stageD.loadUnsigned = wb.LoadUnsigned;
        stageD.byteOffset   = wb.ByteOffset;
        stageD.moveMode     = wb.MoveMode;
    end

    // Stage register. Reset beats flush, flush beats stall. A flush only
    // drops valid: the payload is dead and may keep its old contents.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            validQ <= 1'b0;
            stageQ <= '0;
        end else if (wb.Flush) begin
            validQ <= 1'b0;
        end else if (!wb.Stall) begin
            validQ <= wb.InValid;
            stageQ <= stageD;
        end
    end

    logic [BYTE_W-1:0] byteLane;
    logic [HALF_W-1:0] halfLane;
    logic [WORD_W-1:0] wordLane;
    logic [DATA_W-1:0] loadData;

    // Little-endian lane pick. The half-word ignores ByteOffset[0] because
    // misaligned halves trap before reaching this stage.
    always_comb begin
        byteLane = '0;
        case (stageQ.byteOffset)
            2'd0:    byteLane = stageQ.memData[7:0];
            2'd1:    byteLane = stageQ.memData[15:8];
            2'd2:    byteLane = stageQ.memData[23:16];
            default: byteLane = stageQ.memData[31:24];
        endcase
        halfLane = stageQ.byteOffset[1] ? stageQ.memData[31:16]
                                        : stageQ.memData[15:0];
        wordLane = stageQ.memData[31:0];
    end

    // Extend the selected lane. Sized casts of signed values replicate the MSB.
    always_comb begin
        loadData = stageQ.memData;
        case (stageQ.loadSize)
            LOAD_BYTE: begin
                if (stageQ.loadUnsigned) loadData = DATA_W'(byteLane);
                else                     loadData = DATA_W'($signed(byteLane));
            end
            LOAD_HALF: begin
                if (stageQ.loadUnsigned) loadData = DATA_W'(halfLane);
                else                     loadData = DATA_W'($signed(halfLane));
            end
            LOAD_WORD: begin
                if (stageQ.loadUnsigned) loadData = DATA_W'(wordLane);
                else                     loadData = DATA_W'($signed(wordLane));
            end
            default:   loadData = stageQ.memData;
        endcase
    end

    logic [DATA_W-1:0] resultData;
    logic              moveOk;

    // Source select and conditional-move qualification.
    always_comb begin
        if (stageQ.hiToReg) begin
            resultData = stageQ.hiOrLo ? stageQ.hi : stageQ.lo;
        end else if (stageQ.memToReg) begin
            resultData = stageQ.aluResult;
        end else begin
            resultData = loadData;
        end

        case (stageQ.moveMode)
            MOVE_ALWAYS: moveOk = 1'b1;
            MOVE_Z:      moveOk = stageQ.zero;
            MOVE_N:      moveOk = ~stageQ.zero;
            default:     moveOk = 1'b0;
        endcase
    end

    // Register $zero is never written. Data and address are driven regardless.
    assign wb.WriteData  = resultData;
    assign wb.WriteReg   = stageQ.writeReg;
    assign wb.RegWriteEn = validQ & stageQ.regWrite & moveOk
                         & (stageQ.writeReg != '0);
    assign wb.Valid      = validQ;

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retireCountQ;

    // An instruction retires when it leaves the stage. A stalled instruction
    // killed by flush never leaves, so it is not counted.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            retireCountQ <= '0;
        end else if (validQ && !wb.Stall) begin
            retireCountQ <= retireCountQ + 32'd1;
        end
    end

    assign wb.RetireCount = retireCountQ;
`endif

endmodule

// File: tb/tb_writeback_stage_p.sv
// Testbench for writeback_stage_p. Drives identical stimulus into a 32-bit
// and a 64-bit instance. Stimulus pushes expected results into per-instance
// queues, and a negedge monitor pops and compares them.
module tb_writeback_stage_p;
    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    writeback_stage_p_if #(.DATA_W(32), .REG_ADDR_W(5)) bus32 ();
    writeback_stage_p_if #(.DATA_W(64), .REG_ADDR_W(5)) bus64 ();

    writeback_stage_p #(.DATA_W(32), .REG_ADDR_W(5)) dut32 (.Clk(Clk), .Rst(Rst), .wb(bus32));
    writeback_stage_p #(.DATA_W(64), .REG_ADDR_W(5)) dut64 (.Clk(Clk), .Rst(Rst), .wb(bus64));

    typedef struct {
        logic        valid;
        logic [63:0] mem, alu, hi, lo;
        logic        zero;
        logic [4:0]  wr;
        logic        regWrite, memToReg, hiToReg, hiOrLo;
        logic [1:0]  loadSize;
        logic        loadUnsigned;
        logic [1:0]  byteOffset, moveMode;
    } stimT;

    typedef struct {
        logic [63:0] wd;
        logic [4:0]  wr;
        logic        we;
    } expT;

    expT q32[$];
    expT q64[$];
    int  nChecks = 0;
    int  nPass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        nChecks++;
        if (act === req) nPass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, req);
    endtask

    // Reference: rules applied with plain shifts and masks on a 64-bit value.
    function automatic expT model(input stimT s, input bit wide);
        expT         e;
        logic [63:0] mask, mem, v;
        int          bits;
        logic        ok;
        mask = wide ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        mem  = s.mem & mask;
        bits = 64;
        if (s.hiToReg)       v = s.hiOrLo ? s.hi : s.lo;
        else if (s.memToReg) v = s.alu;
        else begin
            case (s.loadSize)
                2'd0:    begin v = (mem >> (8 * s.byteOffset)) & 64'hFF;        bits = 8;  end
                2'd1:    begin v = (mem >> (16 * s.byteOffset[1])) & 64'hFFFF;  bits = 16; end
                2'd2:    begin v = mem & 64'hFFFF_FFFF;                         bits = 32; end
                default: begin v = mem;                                          bits = 64; end
            endcase
            if (!s.loadUnsigned && bits < 64 && v[bits-1]) v = v | ~((64'd1 << bits) - 64'd1);
        end
        ok   = (s.moveMode == 2'd0) || (s.moveMode == 2'd1 && s.zero) ||
               (s.moveMode == 2'd2 && !s.zero);
        e.wd = v & mask;
        e.wr = s.wr;
        e.we = ok && s.regWrite && (s.wr != 5'd0);
        return e;
    endfunction

    function automatic stimT baseStim();
        stimT s;
        s.valid = 1'b1; s.mem = '0; s.alu = '0; s.hi = '0; s.lo = '0; s.zero = 1'b0;
        s.wr = 5'd5; s.regWrite = 1'b1; s.memToReg = 1'b0; s.hiToReg = 1'b0;
        s.hiOrLo = 1'b0; s.loadSize = 2'd0; s.loadUnsigned = 1'b0;
        s.byteOffset = 2'd0; s.moveMode = 2'd0;
        return s;
    endfunction

    function automatic stimT randStim();
        stimT s;
        s.valid        = ($urandom_range(0, 9) != 0);
        s.mem          = {$urandom, $urandom};
        s.alu          = {$urandom, $urandom};
        s.hi           = {$urandom, $urandom};
        s.lo           = {$urandom, $urandom};
        s.zero         = 1'($urandom);
        s.wr           = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        s.regWrite     = ($urandom_range(0, 4) != 0);
        s.memToReg     = 1'($urandom);
        s.hiToReg      = ($urandom_range(0, 3) == 0);
        s.hiOrLo       = 1'($urandom);
        s.loadSize     = 2'($urandom);
        s.loadUnsigned = 1'($urandom);
        s.byteOffset   = 2'($urandom);
        s.moveMode     = 2'($urandom);
        return s;
    endfunction

    // One cycle of stimulus, driven just after the active edge. Expectations
    // are pushed only when the next edge will actually capture the instruction.
    task automatic step(input stimT s, input bit st, input bit fl, input bit rs,
                        input bit useExp, input expT e32, input expT e64);
        @(posedge Clk);
        #1;
        Rst = rs;
        bus32.Stall = st;  bus64.Stall = st;
        bus32.Flush = fl;  bus64.Flush = fl;
        bus32.InValid = s.valid;            bus64.InValid = s.valid;
        bus32.MemoryReadData = s.mem[31:0]; bus64.MemoryReadData = s.mem;
        bus32.ALUResult = s.alu[31:0];      bus64.ALUResult = s.alu;
        bus32.ReadDataHi = s.hi[31:0];      bus64.ReadDataHi = s.hi;
        bus32.ReadDataLo = s.lo[31:0];      bus64.ReadDataLo = s.lo;
        bus32.Zero = s.zero;                bus64.Zero = s.zero;
        bus32.InWriteReg = s.wr;            bus64.InWriteReg = s.wr;
        bus32.InRegWrite = s.regWrite;      bus64.InRegWrite = s.regWrite;
        bus32.MemToReg = s.memToReg;        bus64.MemToReg = s.memToReg;
        bus32.HiToReg = s.hiToReg;          bus64.HiToReg = s.hiToReg;
        bus32.HiOrLo = s.hiOrLo;            bus64.HiOrLo = s.hiOrLo;
        bus32.LoadSize = s.loadSize;        bus64.LoadSize = s.loadSize;
        bus32.LoadUnsigned = s.loadUnsigned; bus64.LoadUnsigned = s.loadUnsigned;
        bus32.ByteOffset = s.byteOffset;    bus64.ByteOffset = s.byteOffset;
        bus32.MoveMode = s.moveMode;        bus64.MoveMode = s.moveMode;
        if (!rs && !fl && !st && s.valid) begin
            q32.push_back(useExp ? e32 : model(s, 1'b0));
            q64.push_back(useExp ? e64 : model(s, 1'b1));
        end
    endtask

    function automatic expT mk(input logic [63:0] wd, input logic [4:0] wr, input logic we);
        expT e;
        e.wd = wd; e.wr = wr; e.we = we;
        return e;
    endfunction

    task automatic send(input stimT s);
        step(s, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0), mk(0, 0, 0));
    endtask

    task automatic sendExp(input stimT s, input expT e32, input expT e64);
        step(s, 1'b0, 1'b0, 1'b0, 1'b1, e32, e64);
    endtask

    task automatic ctl(input stimT s, input bit st, input bit fl, input bit rs);
        step(s, st, fl, rs, 1'b0, mk(0, 0, 0), mk(0, 0, 0));
    endtask

    // Monitor: compares stage outputs against the scoreboard and a small
    // occupancy/retire model advanced with the inputs seen before each edge.
    logic rstSeen = 1'b0;
    logic mValid  = 1'b0;
    int unsigned expCount = 0;

    always @(posedge Clk) rstSeen <= Rst;

    always @(negedge Clk) begin
        expT e;
        logic wasValid;
        check("valid32", bus32.Valid, mValid);
        check("valid64", bus64.Valid, mValid);
        if (rstSeen) begin
            check("rst_wd32", bus32.WriteData, 0);
            check("rst_wr32", bus32.WriteReg, 0);
            check("rst_wd64", bus64.WriteData, 0);
            check("rst_wr64", bus64.WriteReg, 0);
        end
        if (mValid) begin
            if (q32.size() == 0 || q64.size() == 0) begin
                check("scoreboard_underflow", 1, 0);
            end else begin
                e = q32[0];
                check("wd32", bus32.WriteData, e.wd);
                check("wr32", bus32.WriteReg, e.wr);
                check("we32", bus32.RegWriteEn, e.we);
                e = q64[0];
                check("wd64", bus64.WriteData, e.wd);
                check("wr64", bus64.WriteReg, e.wr);
                check("we64", bus64.RegWriteEn, e.we);
            end
        end else begin
            check("we32_idle", bus32.RegWriteEn, 0);
            check("we64_idle", bus64.RegWriteEn, 0);
        end
`ifdef WB_RETIRE_CNT_EN
        check("retire32", bus32.RetireCount, expCount);
        check("retire64", bus64.RetireCount, expCount);
`endif
        wasValid = mValid;
        if (Rst) begin
            mValid   = 1'b0;
            expCount = 0;
        end else begin
            if (mValid && !bus32.Stall) expCount = expCount + 1;
            if (bus32.Flush)            mValid = 1'b0;
            else if (!bus32.Stall)      mValid = bus32.InValid;
        end
        if (wasValid && (Rst || bus32.Flush || !bus32.Stall) && q32.size() > 0) begin
            void'(q32.pop_front());
            void'(q64.pop_front());
        end
    end

    initial begin
        stimT s, idle;
        idle = baseStim();
        idle.valid = 1'b0;

        // Reset with random inputs.
        ctl(randStim(), 1'b0, 1'b0, 1'b1);
        ctl(randStim(), 1'b0, 1'b0, 1'b1);

        // Byte loads from 0x80FF7F01.
        s = baseStim();
        s.mem = 64'h0000_0000_80FF_7F01;
        s.byteOffset = 2'd3;
        sendExp(s, mk(64'hFFFF_FF80, 5, 1), mk(64'hFFFF_FFFF_FFFF_FF80, 5, 1));
        s.loadUnsigned = 1'b1;
        sendExp(s, mk(64'h0000_0080, 5, 1), mk(64'h80, 5, 1));
        s.loadUnsigned = 1'b0; s.byteOffset = 2'd1;
        sendExp(s, mk(64'h0000_007F, 5, 1), mk(64'h7F, 5, 1));

        // Half and full-width loads.
        s = baseStim();
        s.mem = 64'h0000_0000_8001_ABCD;
        s.loadSize = 2'd1; s.byteOffset = 2'd2;
        sendExp(s, mk(64'hFFFF_8001, 5, 1), mk(64'hFFFF_FFFF_FFFF_8001, 5, 1));
        s.loadSize = 2'd3;
        sendExp(s, mk(64'h8001_ABCD, 5, 1), mk(64'h0000_0000_8001_ABCD, 5, 1));
        s.mem = 64'h8765_4321_8001_ABCD; s.loadSize = 2'd2;
        sendExp(s, mk(64'h8001_ABCD, 5, 1), mk(64'hFFFF_FFFF_8001_ABCD, 5, 1));

        // MOVZ / MOVN / $zero destination.
        s = baseStim();
        s.alu = 64'h1234; s.memToReg = 1'b1;
        s.moveMode = 2'd1; s.zero = 1'b1; sendExp(s, mk(64'h1234, 5, 1), mk(64'h1234, 5, 1));
        s.zero = 1'b0;                    sendExp(s, mk(64'h1234, 5, 0), mk(64'h1234, 5, 0));
        s.moveMode = 2'd2; s.zero = 1'b1; sendExp(s, mk(64'h1234, 5, 0), mk(64'h1234, 5, 0));
        s.zero = 1'b0;                    sendExp(s, mk(64'h1234, 5, 1), mk(64'h1234, 5, 1));
        s.moveMode = 2'd3;                sendExp(s, mk(64'h1234, 5, 0), mk(64'h1234, 5, 0));
        s.moveMode = 2'd0; s.wr = 5'd0;   sendExp(s, mk(64'h1234, 0, 0), mk(64'h1234, 0, 0));

        // HI / LO select.
        s = baseStim();
        s.hiToReg = 1'b1; s.hi = 64'hAAAA_0000; s.lo = 64'h5555;
        s.hiOrLo = 1'b1; sendExp(s, mk(64'hAAAA_0000, 5, 1), mk(64'hAAAA_0000, 5, 1));
        s.hiOrLo = 1'b0; sendExp(s, mk(64'h5555, 5, 1), mk(64'h5555, 5, 1));

        // Stall, then flush while stalled: only the first instruction retires.
        ctl(idle, 1'b0, 1'b0, 1'b1);
        s = baseStim(); s.memToReg = 1'b1;
        s.alu = 64'h11; s.wr = 5'd1; send(s);
        s.alu = 64'h22; s.wr = 5'd2; send(s);
        s.alu = 64'h33; s.wr = 5'd3;
        ctl(s, 1'b1, 1'b0, 1'b0);
        ctl(s, 1'b1, 1'b0, 1'b0);
        ctl(s, 1'b1, 1'b1, 1'b0);
        ctl(idle, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        check("flush_valid", bus32.Valid, 0);
`ifdef WB_RETIRE_CNT_EN
        check("retire_after_flush", bus32.RetireCount, 1);
`endif

        // Random traffic with stalls, flushes and occasional resets.
        for (int i = 0; i < 400; i++) begin
            ctl(randStim(), ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 49) == 0));
        end

        for (int i = 0; i < 4; i++) ctl(idle, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        check("drain32", q32.size(), 0);
        check("drain64", q64.size(), 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
